// File: rtl/rx_stat_ctrl_pkg.sv
// Shared types and constants for the receive statistics counter controller.
package rx_stat_ctrl_pkg;

    localparam int NUM_EVT_DEF = 13;
    localparam int CNT_W_DEF   = 32;
    localparam int ADDR_W_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EV_RD,
        ST_EV_WAIT,
        ST_EV_WR,
        ST_H_RD,
        ST_H_WAIT,
        ST_H_ACK,
        ST_CLR
    } state_t;

    // Statistics-vector bit positions; each one is also its counter's RAM address.
    localparam int EVT_GOOD_FRAME = 0;
    localparam int EVT_BAD_FRAME  = 1;
    localparam int EVT_CRC_ERR    = 2;
    localparam int EVT_LEN_ERR    = 3;
    localparam int EVT_PAUSE      = 4;
    localparam int EVT_VLAN       = 5;
    localparam int EVT_BCAST      = 6;
    localparam int EVT_MCAST      = 7;
    localparam int EVT_UNDERSIZE  = 8;
    localparam int EVT_OVERSIZE   = 9;
    localparam int EVT_FRAGMENT   = 10;
    localparam int EVT_JABBER     = 11;
    localparam int EVT_ALIGN_ERR  = 12;

endpackage

// File: rtl/rx_stat_rr_pick.sv
// Combinational round-robin picker: lowest pending index at or above ptr, wrapping to 0.
module rx_stat_rr_pick #(
    parameter int NUM_EVT = 13,
    parameter int ADDR_W  = 4
) (
    input  logic [NUM_EVT-1:0] pend,
    input  logic [ADDR_W-1:0]  ptr,
    output logic [ADDR_W-1:0]  gnt,
    output logic               vld
);

    int j;
    logic [ADDR_W-1:0] jj;

    // Scan from the farthest offset down so the nearest pending index is written last.
    always_comb begin
        gnt = '0;
        vld = |pend;
        j   = 0;
        jj  = '0;
        for (int k = NUM_EVT - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_EVT) j = j - NUM_EVT;
            jj = ADDR_W'(j);
            if (pend[jj]) gnt = jj;
        end
    end

endmodule

// File: rtl/rx_stat_ctrl.sv
// Receive statistics controller: queues event pulses as backlogs and applies them to the
// counter RAM by read-modify-write, arbitrated against host reads and a clear-all sweep.
module rx_stat_ctrl
    import rx_stat_ctrl_pkg::*;
#(
    parameter int NUM_EVT     = NUM_EVT_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SATURATE    = 0,
    parameter int CLR_ON_READ = 0
) (
    input  logic               rxclk,
    input  logic               reset,
    input  logic [NUM_EVT-1:0] stat_evt,
    input  logic               host_rd_req,
    input  logic [ADDR_W-1:0]  host_rd_addr,
    output logic               host_rd_ack,
    output logic [CNT_W-1:0]   host_rd_data,
    input  logic               host_clr,
    output logic               ram_en,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [CNT_W-1:0]   ram_wdata,
    input  logic [CNT_W-1:0]   ram_rdata,
    output logic               stat_lost,
    output logic               busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_EVT - 1);

    state_t                   state, state_nxt;
    logic [NUM_EVT-1:0][1:0]  backlog;
    logic [NUM_EVT-1:0]       pend, full, svc;
    logic [ADDR_W-1:0]        rr_ptr, cur_idx, pick_idx, h_addr, clr_idx;
    logic                     pick_vld, h_valid, clr_pend, last_host;
    logic                     lost_now, addr_ok, clr_done;
    logic [CNT_W-1:0]         rdata_q, wr_val;

    always_comb begin
        pend = '0;
        full = '0;
        for (int i = 0; i < NUM_EVT; i++) begin
            pend[i] = |backlog[i];
            full[i] = &backlog[i];
        end
    end

    // The backlog entry being serviced is decremented in EV_RD.
    always_comb begin
        svc = '0;
        if (state == ST_EV_RD) svc[cur_idx] = 1'b1;
    end

    assign lost_now = |(stat_evt & full & ~svc);
    assign addr_ok  = int'(host_rd_addr) < NUM_EVT;
    assign clr_done = (state == ST_CLR) && (clr_idx == LAST_IDX);
    assign wr_val   = ((SATURATE != 0) && (&rdata_q)) ? rdata_q : rdata_q + CNT_W'(1);

    rx_stat_rr_pick #(.NUM_EVT(NUM_EVT), .ADDR_W(ADDR_W)) u_pick (
        .pend (pend),
        .ptr  (rr_ptr),
        .gnt  (pick_idx),
        .vld  (pick_vld)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (clr_pend)                                   state_nxt = ST_CLR;
                else if (host_rd_req && !(last_host && pick_vld)) state_nxt = ST_H_RD;
                else if (pick_vld)                              state_nxt = ST_EV_RD;
            end
            ST_EV_RD:   state_nxt = ST_EV_WAIT;
            ST_EV_WAIT: state_nxt = ST_EV_WR;
            ST_EV_WR: begin
                if (pick_vld && !host_rd_req && !clr_pend) state_nxt = ST_EV_RD;
                else                                       state_nxt = ST_IDLE;
            end
            ST_H_RD:    state_nxt = ST_H_WAIT;
            ST_H_WAIT:  state_nxt = ST_H_ACK;
            ST_H_ACK:   state_nxt = ST_IDLE;
            ST_CLR:     if (clr_done) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            ST_EV_RD: begin
                ram_en   = 1'b1;
                ram_addr = cur_idx;
            end
            ST_EV_WR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = cur_idx;
                ram_wdata = wr_val;
            end
            ST_H_RD: begin
                if (addr_ok) begin
                    ram_en   = 1'b1;
                    ram_addr = host_rd_addr;
                end
            end
            ST_H_ACK: begin
                if ((CLR_ON_READ != 0) && h_valid) begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = h_addr;
                end
            end
            ST_CLR: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = clr_idx;
            end
            default: ;
        endcase
    end

    assign host_rd_ack = (state == ST_H_ACK);
    assign busy        = (state != ST_IDLE) || (|pend);

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            backlog      <= '0;
            rr_ptr       <= '0;
            cur_idx      <= '0;
            h_addr       <= '0;
            h_valid      <= 1'b0;
            clr_idx      <= '0;
            clr_pend     <= 1'b0;
            last_host    <= 1'b0;
            rdata_q      <= '0;
            host_rd_data <= '0;
            stat_lost    <= 1'b0;
        end else begin
            state <= state_nxt;

            for (int i = 0; i < NUM_EVT; i++) begin
                if (stat_evt[i] && !svc[i] && !full[i])
                    backlog[i] <= backlog[i] + 2'd1;
                else if (!stat_evt[i] && svc[i])
                    backlog[i] <= backlog[i] - 2'd1;
            end

            if (state_nxt == ST_EV_RD) cur_idx <= pick_idx;

            if (state == ST_EV_RD) begin
                rr_ptr    <= (cur_idx == LAST_IDX) ? '0 : cur_idx + ADDR_W'(1);
                last_host <= 1'b0;
            end

            if (state == ST_EV_WAIT) rdata_q <= ram_rdata;

            if (state == ST_H_RD) begin
                h_addr  <= host_rd_addr;
                h_valid <= addr_ok;
            end

            if (state == ST_H_WAIT) host_rd_data <= h_valid ? ram_rdata : '0;
            if (state == ST_H_ACK)  last_host <= 1'b1;

            if (state == ST_CLR) clr_idx <= clr_done ? '0 : clr_idx + ADDR_W'(1);

            // A new clear request during the sweep is absorbed by the sweep itself.
            if (clr_done)                          clr_pend <= 1'b0;
            else if (host_clr && state != ST_CLR)  clr_pend <= 1'b1;

            if (lost_now)      stat_lost <= 1'b1;
            else if (clr_done) stat_lost <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_stat_ctrl.sv
// Bench for rx_stat_ctrl: a wrapping/no-clear instance and a saturating/clear-on-read
// instance share stimulus, each with its own RAM model; host reads go through a scoreboard.
module tb_rx_stat_ctrl;
    import rx_stat_ctrl_pkg::*;

    localparam int N = 13;

    logic          rxclk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  stat_evt = '0;
    logic          host_rd_req = 1'b0;
    logic [3:0]    host_rd_addr = '0;
    logic          host_clr = 1'b0;

    logic          a_ack, a_en, a_we, a_lost, a_busy;
    logic [31:0]   a_data, a_wdata, a_rdata;
    logic [3:0]    a_addr;
    logic          b_ack, b_en, b_we, b_lost, b_busy;
    logic [31:0]   b_data, b_wdata, b_rdata;
    logic [3:0]    b_addr;

    logic [31:0]   mem_a [16];
    logic [31:0]   mem_b [16];
    logic [31:0]   exp_a [$];
    logic [31:0]   exp_b [$];
    logic [3:0]    rd_log [$];

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 rxclk = ~rxclk;

    rx_stat_ctrl dut_a (
        .rxclk(rxclk), .reset(reset), .stat_evt(stat_evt),
        .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr),
        .host_rd_ack(a_ack), .host_rd_data(a_data), .host_clr(host_clr),
        .ram_en(a_en), .ram_we(a_we), .ram_addr(a_addr), .ram_wdata(a_wdata),
        .ram_rdata(a_rdata), .stat_lost(a_lost), .busy(a_busy)
    );

    rx_stat_ctrl #(.SATURATE(1), .CLR_ON_READ(1)) dut_b (
        .rxclk(rxclk), .reset(reset), .stat_evt(stat_evt),
        .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr),
        .host_rd_ack(b_ack), .host_rd_data(b_data), .host_clr(host_clr),
        .ram_en(b_en), .ram_we(b_we), .ram_addr(b_addr), .ram_wdata(b_wdata),
        .ram_rdata(b_rdata), .stat_lost(b_lost), .busy(b_busy)
    );

    always @(posedge rxclk) begin
        if (a_en) begin
            if (a_we) mem_a[a_addr] <= a_wdata;
            else      a_rdata <= mem_a[a_addr];
        end
        if (b_en) begin
            if (b_we) mem_b[b_addr] <= b_wdata;
            else      b_rdata <= mem_b[b_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ack pops the expected data for that instance.
    always @(negedge rxclk) begin
        if (a_en && !a_we) rd_log.push_back(a_addr);
        if (a_ack) begin
            if (exp_a.size() == 0) chk("rd_a_unexpected", a_data, 32'hxxxx_xxxx);
            else                   chk("rd_a", a_data, exp_a.pop_front());
        end
        if (b_ack) begin
            if (exp_b.size() == 0) chk("rd_b_unexpected", b_data, 32'hxxxx_xxxx);
            else                   chk("rd_b", b_data, exp_b.pop_front());
        end
    end

    task automatic tick();
        @(posedge rxclk);
        #1;
    endtask

    task automatic poke(input logic [3:0] addr, input logic [31:0] val);
        mem_a[addr] <= val;
        mem_b[addr] <= val;
    endtask

    task automatic zero_mems();
        for (int i = 0; i < 16; i++) poke(4'(i), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        tick();
        tick();
        n = 0;
        while ((a_busy || b_busy) && n < budget) begin
            tick();
            n++;
        end
        if (a_busy || b_busy) chk("wait_idle_timeout", 32'(a_busy), 32'd0);
    endtask

    task automatic host_read(input logic [3:0] addr, input logic [31:0] ea,
                             input logic [31:0] eb, output int l);
        exp_a.push_back(ea);
        exp_b.push_back(eb);
        host_rd_addr = addr;
        host_rd_req  = 1'b1;
        l = 0;
        do begin
            tick();
            l++;
        end while (!a_ack && l < 20);
        host_rd_req = 1'b0;
    endtask

    initial begin
        zero_mems();
        tick();
        tick();
        chk("reset_outs", 32'({a_en, a_we, a_ack, a_lost, a_busy, b_en, b_we, b_ack, b_lost, b_busy}), 32'd0);
        chk("reset_data", a_data | b_data, 32'd0);
        reset = 1'b0;
        poke(4'd0, 32'd5);
        tick();

        // Single pulse: read two cycles later, write back 6.
        stat_evt[EVT_GOOD_FRAME] = 1'b1;
        tick();
        stat_evt = '0;
        chk("t1_busy_pend", 32'(a_busy), 32'd1);
        tick();
        chk("t1_rd", 32'({a_en, a_we, a_addr}), 32'({1'b1, 1'b0, 4'd0}));
        tick();
        tick();
        chk("t1_wr", 32'({a_en, a_we, a_addr}), 32'({1'b1, 1'b1, 4'd0}));
        chk("t1_wdata", a_wdata, 32'd6);
        tick();
        chk("t1_busy_done", 32'(a_busy), 32'd0);
        chk("t1_mem", mem_a[0], 32'd6);

        // All events at once from pointer 0: 13 updates back to back.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        zero_mems();
        tick();
        rd_log.delete();
        stat_evt = '1;
        tick();
        stat_evt = '0;
        repeat (39) tick();
        chk("t2_last_wr", 32'({a_busy, a_we, a_addr}), 32'({1'b1, 1'b1, 4'd12}));
        tick();
        chk("t2_idle", 32'(a_busy), 32'd0);
        chk("t2_nreads", 32'(rd_log.size()), 32'd13);
        for (int i = 0; i < 13 && i < rd_log.size(); i++) chk("t2_order", 32'(rd_log[i]), 32'(i));
        for (int i = 0; i < 13; i++) chk("t2_cnt", mem_a[i], 32'd1);
        chk("t2_lost", 32'({a_lost, b_lost}), 32'd0);

        // Backlog overflow, then clear-all.
        zero_mems();
        stat_evt[EVT_LEN_ERR] = 1'b1;
        repeat (5) tick();
        stat_evt = '0;
        wait_idle(50);
        chk("t3_cnt", mem_a[3], 32'd4);
        chk("t3_lost", 32'({a_lost, b_lost}), 32'b11);
        host_clr = 1'b1;
        tick();
        host_clr = 1'b0;
        wait_idle(50);
        for (int i = 0; i < 13; i++) chk("t3_clr", mem_a[i] | mem_b[i], 32'd0);
        chk("t3_lost_clr", 32'({a_lost, b_lost}), 32'd0);

        // Wrap versus saturate.
        poke(4'd2, 32'hFFFF_FFFF);
        tick();
        stat_evt[EVT_CRC_ERR] = 1'b1;
        tick();
        stat_evt = '0;
        wait_idle(50);
        chk("t4_wrap", mem_a[2], 32'h0000_0000);
        chk("t4_sat", mem_b[2], 32'hFFFF_FFFF);

        // Host reads: during an event stream, clear-on-read, out-of-range address.
        poke(4'd7, 32'h1234);
        stat_evt[EVT_GOOD_FRAME] = 1'b1;
        stat_evt[EVT_BAD_FRAME]  = 1'b1;
        repeat (4) tick();
        host_read(4'd7, 32'h1234, 32'h1234, lat);
        stat_evt = '0;
        chk("t5_lat_stream", 32'(lat <= 6), 32'd1);
        wait_idle(100);
        host_read(4'd7, 32'h1234, 32'd0, lat);
        chk("t5_lat_idle", 32'(lat), 32'd3);
        tick();
        host_read(4'd14, 32'd0, 32'd0, lat);
        chk("t5_lat_oob", 32'(lat), 32'd3);
        tick();

        // Clear requested during an RMW; event arriving mid-sweep is applied after it.
        zero_mems();
        poke(4'd5, 32'd7);
        stat_evt[EVT_PAUSE] = 1'b1;
        tick();
        stat_evt = '0;
        tick();
        chk("t6_ev_rd", 32'({a_en, a_we, a_addr}), 32'({1'b1, 1'b0, 4'd4}));
        host_clr = 1'b1;
        tick();
        host_clr = 1'b0;
        tick();
        chk("t6_ev_wr", 32'({a_we, a_addr}), 32'({1'b1, 4'd4}));
        chk("t6_ev_wdata", a_wdata, 32'd1);
        tick();
        tick();
        chk("t6_clr_first", 32'({a_we, a_addr}), 32'({1'b1, 4'd0}));
        chk("t6_clr_wdata", a_wdata, 32'd0);
        stat_evt[EVT_OVERSIZE] = 1'b1;
        tick();
        stat_evt = '0;
        repeat (11) tick();
        chk("t6_clr_last", 32'({a_we, a_addr}), 32'({1'b1, 4'd12}));
        tick();
        chk("t6_after_sweep", 32'({a_en, a_busy}), 32'({1'b0, 1'b1}));
        tick();
        chk("t6_late_ev", 32'({a_en, a_we, a_addr}), 32'({1'b1, 1'b0, 4'd9}));
        wait_idle(50);
        chk("t6_cnt9", mem_a[9], 32'd1);
        chk("t6_cnt4", mem_a[4], 32'd0);
        chk("t6_cnt5", mem_a[5], 32'd0);
        chk("t6_lost", 32'(a_lost), 32'd0);
        host_read(4'd9, 32'd1, 32'd1, lat);
        repeat (3) tick();
        chk("t6_hold", a_data, 32'd1);

        // Reset in the middle of EV_WAIT.
        stat_evt[EVT_BAD_FRAME] = 1'b1;
        tick();
        stat_evt = '0;
        tick();
        tick();
        chk("t7_wait", 32'({a_en, a_busy}), 32'({1'b0, 1'b1}));
        reset = 1'b1;
        #1;
        chk("t7_reset_outs", 32'({a_en, a_we, a_ack, a_lost, a_busy, b_en, b_we, b_busy}), 32'd0);
        chk("t7_reset_data", a_data | b_data, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        chk("sb_empty", 32'(exp_a.size() + exp_b.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
